// File: rtl/parity_frame_rx.sv
// rtl/parity_frame_rx.sv - serial receiver and parity/framing checker for parity-protected frames
module parity_frame_rx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy,
  output logic                 led
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE
  } state_t;

  state_t               state;
  logic [TW-1:0]        timer;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shift;
  logic                 p_rx;
  logic                 s1;
  logic                 rs;

  // Two-flop synchronizer for the asynchronous line; resets to the idle (high) level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      rs <= 1'b1;
    end else begin
      s1 <= rx;
      rs <= s1;
    end
  end

  // Frame FSM: mid-bit sampling, data shift-in, and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      timer      <= '0;
      idx        <= '0;
      shift      <= '0;
      p_rx       <= 1'b0;
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
      led        <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          idx   <= '0;
          if (!rs) begin
            state <= START;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (timer == T_HALF) begin
            timer <= '0;
            idx   <= '0;
            if (!rs) begin
              state <= DATA;
            end else begin
              // Line went back high before mid-bit: a glitch, not a start bit.
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        DATA: begin
          if (timer == T_LAST) begin
            timer <= '0;
            // LSB-first: each new bit enters at the top and moves down.
            shift <= (shift >> 1) | (DATA_BITS'(rs) << (DATA_BITS - 1));
            if (idx == I_LAST) begin
              state <= PARITY;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        PARITY: begin
          if (timer == T_LAST) begin
            timer <= '0;
            p_rx  <= rs;
            state <= STOP;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        STOP: begin
          if (timer == T_LAST) begin
            // Results are loaded on entry to DONE so they appear with the valid pulse.
            timer      <= '0;
            state      <= DONE;
            valid      <= 1'b1;
            data_out   <= shift;
            parity_err <= (^shift) != p_rx;
            frame_err  <= ~rs;
            led        <= ^shift;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_frame_rx.sv
// tb/tb_parity_frame_rx.sv - scoreboard testbench for parity_frame_rx
module tb_parity_frame_rx;

  localparam int CPB = 4;
  localparam int DB  = 4;
  localparam int LAT = CPB / 2 + (DB + 2) * CPB + 1;

  logic          clk;
  logic          rst_n;
  logic          rx;
  logic [DB-1:0] data_out;
  logic          valid;
  logic          parity_err;
  logic          frame_err;
  logic          busy;
  logic          led;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [DB-1:0] data;
    logic          perr;
    logic          ferr;
    logic          led;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   valid_log[$];

  parity_frame_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .data_out   (data_out),
    .valid      (valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy),
    .led        (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every valid pulse must match the oldest expected frame.
  always @(posedge clk) begin
    #1;
    if (rst_n && valid) begin
      valid_log.push_back(cyc);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid cycle=%0d data_out=%b", cyc, data_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (cyc !== e.cyc) begin
          errors++;
          $display("FAIL latency got_cycle=%0d want_cycle=%0d", cyc, e.cyc);
        end
        checks++;
        if (data_out !== e.data) begin
          errors++;
          $display("FAIL data_out got=%b want=%b", data_out, e.data);
        end
        checks++;
        if (parity_err !== e.perr) begin
          errors++;
          $display("FAIL parity_err got=%b want=%b", parity_err, e.perr);
        end
        checks++;
        if (frame_err !== e.ferr) begin
          errors++;
          $display("FAIL frame_err got=%b want=%b", frame_err, e.ferr);
        end
        checks++;
        if (led !== e.led) begin
          errors++;
          $display("FAIL led got=%b want=%b", led, e.led);
        end
      end
    end
  end

  // Must be called right at a rising edge; returns at a rising edge with rx left at the stop level.
  task automatic send_frame(input logic [DB-1:0] d, input logic p, input logic s);
    exp_t e;
    #1;
    rx     = 1'b0;
    e.data = d;
    e.perr = (^d) != p;
    e.ferr = ~s;
    e.led  = ^d;
    e.cyc  = cyc + 2 + LAT;
    sb.push_back(e);
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < DB; i++) begin
      #1 rx = d[i];
      repeat (CPB) @(posedge clk);
    end
    #1 rx = p;
    repeat (CPB) @(posedge clk);
    #1 rx = s;
    repeat (CPB) @(posedge clk);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout pending=%0d want=0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({data_out, valid, parity_err, frame_err, busy, led} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=0", {data_out, valid, parity_err, frame_err, busy, led});
    end
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_good_frame;
    send_frame(4'b0101, 1'b0, 1'b1);
    wait_drain("good_0101");
    #1 rx = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_parity;
    send_frame(4'b0111, 1'b1, 1'b1);
    send_frame(4'b0111, 1'b0, 1'b1);
    wait_drain("parity");
    #1 rx = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_frame_err;
    send_frame(4'b1001, 1'b0, 1'b0);
    #1 rx = 1'b1;
    wait_drain("frame_err");
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL frame_err_idle busy got=%b want=0", busy);
    end
  endtask

  task automatic test_glitch;
    @(posedge clk);
    #1 rx = 1'b0;
    @(posedge clk);
    #1 rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL glitch_start busy got=%b want=1", busy);
    end
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_idle busy got=%b want=0", busy);
    end
    checks++;
    if ({data_out, parity_err, frame_err, led} !== {4'b1001, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL glitch_hold got=%b want=%b", {data_out, parity_err, frame_err, led},
               {4'b1001, 1'b0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_back_to_back;
    int n0;
    n0 = valid_log.size();
    @(posedge clk);
    send_frame(4'b0001, 1'b1, 1'b1);
    send_frame(4'b1111, 1'b0, 1'b1);
    wait_drain("back_to_back");
    checks++;
    if (valid_log.size() != n0 + 2) begin
      errors++;
      $display("FAIL b2b_count got=%0d want=2", valid_log.size() - n0);
    end else begin
      checks++;
      if (valid_log[n0 + 1] - valid_log[n0] != 7 * CPB) begin
        errors++;
        $display("FAIL b2b_spacing got=%0d want=%0d", valid_log[n0 + 1] - valid_log[n0], 7 * CPB);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    int n0;
    n0 = valid_log.size();
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_frame_busy got=%b want=1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({data_out, valid, parity_err, frame_err, busy, led} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs got=%b want=0", {data_out, valid, parity_err, frame_err, busy, led});
    end
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if ({data_out, busy} !== '0 || valid_log.size() != n0) begin
      errors++;
      $display("FAIL post_reset_quiet data_out=%b busy=%b valids=%0d want 0,0,0",
               data_out, busy, valid_log.size() - n0);
    end
  endtask

  initial begin
    test_reset();
    @(posedge clk);
    test_good_frame();
    @(posedge clk);
    test_parity();
    @(posedge clk);
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
